// File: rtl/cmul_share_arb_pkg.sv
// Q-format constants and helpers shared by the complex-multiply arbiter and its core.
// Saturation helpers are only used when CMUL_SAT_EN is defined.
`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 13
`endif
`ifndef FRACTION_BITS
`define FRACTION_BITS 8
`endif

package cmul_share_arb_pkg;

    localparam int FIXED_POINT_WIDTH = `FIXED_POINT_WIDTH;
    localparam int FRACTION_BITS     = `FRACTION_BITS;
    localparam int FULL_WIDTH        = 2 * FIXED_POINT_WIDTH + 2;

    typedef logic signed [FULL_WIDTH-1:0]        full_t;
    typedef logic signed [FIXED_POINT_WIDTH-1:0] fix_t;

    localparam full_t Q_MAX = {{(FULL_WIDTH-FIXED_POINT_WIDTH+1){1'b0}}, {(FIXED_POINT_WIDTH-1){1'b1}}};
    localparam full_t Q_MIN = {{(FULL_WIDTH-FIXED_POINT_WIDTH+1){1'b1}}, {(FIXED_POINT_WIDTH-1){1'b0}}};

    // Shift the magnitude so negative values round toward zero, not toward -inf.
    function automatic full_t trunc_scale(input full_t x, input int sh);
        full_t mag_v;
        full_t res_v;
        if (x[FULL_WIDTH-1]) begin
            mag_v = -x;
            res_v = -(mag_v >> sh);
        end else begin
            mag_v = x;
            res_v = mag_v >> sh;
        end
        return res_v;
    endfunction

    function automatic logic is_over(input full_t x);
        return (x > Q_MAX) || (x < Q_MIN);
    endfunction

    function automatic fix_t saturate(input full_t x);
        fix_t res_v;
        if (x > Q_MAX) begin
            res_v = Q_MAX[FIXED_POINT_WIDTH-1:0];
        end else if (x < Q_MIN) begin
            res_v = Q_MIN[FIXED_POINT_WIDTH-1:0];
        end else begin
            res_v = x[FIXED_POINT_WIDTH-1:0];
        end
        return res_v;
    endfunction

endpackage

// File: rtl/cmul_share_arb_cmul_core.sv
// Combinational complex multiply (optional conj(b)) with truncate-toward-zero scaling.
// CMUL_SAT_EN selects clamping plus a sat output instead of wrap-around.
module cmul_core
    import cmul_share_arb_pkg::*;
#(
    parameter int FRAC = FRACTION_BITS
) (
    input  logic [FIXED_POINT_WIDTH-1:0] a_re,
    input  logic [FIXED_POINT_WIDTH-1:0] a_im,
    input  logic [FIXED_POINT_WIDTH-1:0] b_re,
    input  logic [FIXED_POINT_WIDTH-1:0] b_im,
    input  logic                         conj,
    output logic [FIXED_POINT_WIDTH-1:0] p_re,
    output logic [FIXED_POINT_WIDTH-1:0] p_im
`ifdef CMUL_SAT_EN
    ,
    output logic                         sat
`endif
);

    localparam int W = FIXED_POINT_WIDTH;

    logic signed [W:0] b_im_x_s;
    logic signed [W:0] b_im_c_s;
    full_t ar_s, ai_s, br_s, bi_s;
    full_t re_full_s, im_full_s, re_scl_s, im_scl_s;

    // Sign-extend everything to full width so no partial sum can overflow
    always_comb begin
        b_im_x_s = {b_im[W-1], b_im};
        if (conj) begin
            b_im_c_s = -b_im_x_s;
        end else begin
            b_im_c_s = b_im_x_s;
        end
        ar_s = {{(FULL_WIDTH-W){a_re[W-1]}}, a_re};
        ai_s = {{(FULL_WIDTH-W){a_im[W-1]}}, a_im};
        br_s = {{(FULL_WIDTH-W){b_re[W-1]}}, b_re};
        bi_s = {{(FULL_WIDTH-W-1){b_im_c_s[W]}}, b_im_c_s};
        re_full_s = ar_s * br_s - ai_s * bi_s;
        im_full_s = ar_s * bi_s + ai_s * br_s;
        re_scl_s  = trunc_scale(re_full_s, FRAC);
        im_scl_s  = trunc_scale(im_full_s, FRAC);
`ifdef CMUL_SAT_EN
        p_re = saturate(re_scl_s);
        p_im = saturate(im_scl_s);
        sat  = is_over(re_scl_s) | is_over(im_scl_s);
`else
        p_re = re_scl_s[W-1:0];
        p_im = im_scl_s[W-1:0];
`endif
    end

endmodule

// File: rtl/cmul_share_arb.sv
// Round-robin sharing of one two-stage complex multiplier among N requesters.
// Define CMUL_SAT_EN for saturating results and the sat_flag output.
module cmul_share_arb
    import cmul_share_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = FIXED_POINT_WIDTH,
    parameter int FRAC = FRACTION_BITS,
    parameter int IDW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N-1:0]   req_conj,
    input  logic [N*W-1:0] req_a_re,
    input  logic [N*W-1:0] req_a_im,
    input  logic [N*W-1:0] req_b_re,
    input  logic [N*W-1:0] req_b_im,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [IDW-1:0] res_id,
    output logic [W-1:0]   res_re,
    output logic [W-1:0]   res_im
`ifdef CMUL_SAT_EN
    ,
    output logic           sat_flag
`endif
);

    logic [IDW-1:0] ptr_r, grant_s, ptr_nxt_s;
    logic           found_s, adv_s, accept_s;
    logic           s1_valid_r, s1_conj_r;
    logic [IDW-1:0] s1_id_r;
    logic [W-1:0]   s1_a_re_r, s1_a_im_r, s1_b_re_r, s1_b_im_r;
    logic [W-1:0]   core_re_s, core_im_s;
`ifdef CMUL_SAT_EN
    logic           core_sat_s;
`endif

    assign adv_s = !res_valid || res_ready;

    // Round-robin search starting at the pointer, wrapping N-1 -> 0
    always_comb begin
        int idx_v;
        idx_v   = 0;
        found_s = 1'b0;
        grant_s = '0;
        for (int k = 0; k < N; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= N) begin
                idx_v = idx_v - N;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req_valid[idx_v[IDW-1:0]]) begin
                found_s = 1'b1;
                grant_s = idx_v[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Ready is offered only to the granted requester, and only while the pipe can advance
    always_comb begin
        req_ready = '0;
        accept_s  = !rst && found_s && adv_s;
        if (accept_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        if (int'(grant_s) == N - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_s + 1'b1;
        end
    end

    // Round-robin pointer moves past the winner only on an accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Stage 1: captured operands, tag and conj flag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_conj_r  <= 1'b0;
            s1_id_r    <= '0;
            s1_a_re_r  <= '0;
            s1_a_im_r  <= '0;
            s1_b_re_r  <= '0;
            s1_b_im_r  <= '0;
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_conj_r <= req_conj[grant_s];
                s1_id_r   <= grant_s;
                s1_a_re_r <= req_a_re[int'(grant_s)*W +: W];
                s1_a_im_r <= req_a_im[int'(grant_s)*W +: W];
                s1_b_re_r <= req_b_re[int'(grant_s)*W +: W];
                s1_b_im_r <= req_b_im[int'(grant_s)*W +: W];
            end else begin
                s1_conj_r <= s1_conj_r;
                s1_id_r   <= s1_id_r;
                s1_a_re_r <= s1_a_re_r;
                s1_a_im_r <= s1_a_im_r;
                s1_b_re_r <= s1_b_re_r;
                s1_b_im_r <= s1_b_im_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    cmul_core #(
        .FRAC (FRAC)
    ) u_core (
        .a_re (s1_a_re_r),
        .a_im (s1_a_im_r),
        .b_re (s1_b_re_r),
        .b_im (s1_b_im_r),
        .conj (s1_conj_r),
        .p_re (core_re_s),
        .p_im (core_im_s)
`ifdef CMUL_SAT_EN
        ,
        .sat  (core_sat_s)
`endif
    );

    // Stage 2: registered result; payload only updates when a real product arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_re    <= '0;
            res_im    <= '0;
`ifdef CMUL_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else if (adv_s) begin
            res_valid <= s1_valid_r;
            if (s1_valid_r) begin
                res_id   <= s1_id_r;
                res_re   <= core_re_s;
                res_im   <= core_im_s;
`ifdef CMUL_SAT_EN
                sat_flag <= core_sat_s;
`endif
            end else begin
                res_id   <= res_id;
                res_re   <= res_re;
                res_im   <= res_im;
            end
        end else begin
            res_valid <= res_valid;
        end
    end

endmodule

// File: tb/tb_cmul_share_arb.sv
// Scoreboard bench for cmul_share_arb: expectations queued at acceptance, checked by a monitor.
`timescale 1ns/1ps
module tb_cmul_share_arb;

    localparam int N   = 4;
    localparam int W   = 13;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_conj;
    logic [N*W-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
    logic           res_valid, res_ready;
    logic [IDW-1:0] res_id;
    logic [W-1:0]   res_re, res_im;
`ifdef CMUL_SAT_EN
    logic           sat_flag;
`endif

    typedef struct {
        logic [IDW-1:0]      id;
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic                sat;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_tab[N];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_res = 0;

    cmul_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_conj  (req_conj),
        .req_a_re  (req_a_re),
        .req_a_im  (req_a_im),
        .req_b_re  (req_b_re),
        .req_b_im  (req_b_im),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_re    (res_re),
        .res_im    (res_im)
`ifdef CMUL_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int are, input int aim, input int bre, input int bim,
                           input logic cj, input int ere, input int eim, input logic es);
        req_a_re[i*W +: W] = W'(are);
        req_a_im[i*W +: W] = W'(aim);
        req_b_re[i*W +: W] = W'(bre);
        req_b_im[i*W +: W] = W'(bim);
        req_conj[i]        = cj;
        exp_tab[i]         = '{id: IDW'(i), re: W'(ere), im: W'(eim), sat: es};
        req_valid[i]       = 1'b1;
    endtask

    // One isolated request with latency checks: ready in T, nothing in T+1, result in T+2
    task automatic run_single(input string nm, input int i, input int are, input int aim,
                              input int bre, input int bim, input logic cj,
                              input int ere, input int eim, input logic es);
        set_req(i, are, aim, bre, bim, cj, ere, eim, es);
        @(negedge clk);
        check({nm, "_ready"}, int'(req_ready), 1 << i);
        tick();
        req_valid = '0;
        @(negedge clk);
        check({nm, "_lat_t1"}, int'(res_valid), 0);
        tick();
        @(negedge clk);
        check({nm, "_lat_t2"}, int'(res_valid), 1);
        tick();
    endtask

    // Monitor: pop and compare on every result handshake, push on every accepted request
    always @(negedge clk) begin
        exp_t e_v;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                n_res++;
                if (sb_q.size() == 0) begin
                    check("unexpected_result_id", int'(res_id), -1);
                end else begin
                    e_v = sb_q.pop_front();
                    check("res_id", int'(res_id), int'(e_v.id));
                    check("res_re", int'($signed(res_re)), int'(e_v.re));
                    check("res_im", int'($signed(res_im)), int'(e_v.im));
`ifdef CMUL_SAT_EN
                    check("sat_flag", int'(sat_flag), int'(e_v.sat));
`endif
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    n_acc++;
                    sb_q.push_back(exp_tab[i]);
                end
            end
        end
    end

    initial begin
        int acc0;
        int res0;
        logic [N-1:0] oh_tab [5];
        oh_tab[0] = 4'b0001; oh_tab[1] = 4'b0010; oh_tab[2] = 4'b0100;
        oh_tab[3] = 4'b1000; oh_tab[4] = 4'b0001;

        rst = 1'b1; res_ready = 1'b1;
        req_valid = 4'b0101; req_conj = '0;
        req_a_re = '0; req_a_im = '0; req_b_re = '0; req_b_im = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_res_re", int'(res_re), 0);
        check("rst_res_im", int'(res_im), 0);
        check("rst_req_ready", int'(req_ready), 0);
        tick();
        req_valid = '0;
        rst = 1'b0;
        tick();

        // (1.5) * (2 - 1j) = 3 - 1.5j, then with conj(b) 3 + 1.5j
        run_single("single", 2, 384, 0, 512, -256, 1'b0, 768, -384, 1'b0);
        run_single("conj", 2, 384, 0, 512, -256, 1'b1, 768, 384, 1'b0);
        run_single("trunc_m1", 1, -1, 0, 1, 0, 1'b0, 0, 0, 1'b0);
        run_single("trunc_257", 3, -256, 0, 257, 0, 1'b0, -257, 0, 1'b0);
        run_single("trunc_neg300", 0, -3, 0, 100, 0, 1'b0, -1, 0, 1'b0);
        run_single("trunc_pos300", 0, 3, 0, 100, 0, 1'b0, 1, 0, 1'b0);
        // conj of b_im = -4096 must be exact: j*1.0 * (+16j) = -16
        run_single("conj_min", 1, 0, 256, 0, -4096, 1'b1, -4096, 0, 1'b0);
`ifdef CMUL_SAT_EN
        run_single("overflow", 0, 4095, 0, 4095, 0, 1'b0, 4095, 0, 1'b1);
`else
        run_single("overflow", 0, 4095, 0, 4095, 0, 1'b0, -32, 0, 1'b0);
`endif
        tick();

        // Reset to bring the pointer back to 0, then all four requesters stay valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc0 = n_acc;
        res0 = n_res;
        for (int i = 0; i < N; i++) begin
            set_req(i, (i + 1) * 256, 0, 256, 256, 1'b0, (i + 1) * 256, (i + 1) * 256, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("rr_grant%0d", k), int'(req_ready), int'(oh_tab[k]));
            tick();
        end

        // Backpressure with S1 and S2 both full
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall_ready%0d", k), int'(req_ready), 0);
            check($sformatf("stall_valid%0d", k), int'(res_valid), 1);
            check($sformatf("stall_id%0d", k), int'(res_id), int'(sb_q[0].id));
            check($sformatf("stall_re%0d", k), int'($signed(res_re)), int'(sb_q[0].re));
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("release_grant1", int'(req_ready), 4'b0010);
        tick();
        @(negedge clk);
        check("release_grant2", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        check("stream_accepts", n_acc - acc0, 7);
        check("stream_results", n_res - res0, 7);
        check("stream_sb_empty", sb_q.size(), 0);

        // Reset while both stages hold products; they must vanish
        set_req(1, 256, 0, 256, 0, 1'b0, 256, 0, 1'b0);
        set_req(3, 512, 0, 256, 0, 1'b0, 512, 0, 1'b0);
        req_valid = 4'b1010;
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", int'(req_ready), 0);
        tick();
        @(negedge clk);
        check("rst_mid_flush", int'(res_valid), 0);
        tick();
        rst = 1'b0;
        res0 = n_res;
        @(negedge clk);
        check("post_rst_grant", int'(req_ready), 4'b0010);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        check("post_rst_results", n_res - res0, 1);
        check("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
